ssm_mbc: RTL and testbench
==========================

# ssm_mbc

Memory bus controller that feeds the ARM-side slave port of the SSM demo design. Accepts read/write requests from the host-side request channel, buffers them in a small FIFO, and issues them one at a time as single-cycle strobes on the `mbc_out_ifc` bus. Read data is captured after a fixed latency and returned on a response channel with valid/ready backpressure. Sits directly upstream of the `arm` block, whose `mbc_out_ifc_*` inputs it drives.

## Interface
- `FIFO_DEPTH`, 4: request FIFO entries; power of 2, 2..16.
- `READ_LATENCY`, 1: cycles from issuing the read strobe to sampling `mbc_out_ifc_read_data`; 1..4.
- `clk` input 1: single clock; all logic is rising-edge.
- `reset` input 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `req_valid` input 1: host request present.
- `req_ready` output 1: FIFO can accept; equals !full.
- `req_write` input 1: 1 = write, 0 = read.
- `req_address` input 32: transaction address.
- `req_write_data` input 32: write payload; ignored for reads.
- `rsp_valid` output 1: read response available.
- `rsp_ready` input 1: host accepts response.
- `rsp_data` output 32: read data.
- `mbc_out_ifc_address` output 32: address to arm.
- `mbc_out_ifc_write_data` output 32: write data to arm.
- `mbc_out_ifc_write` output 1: one-cycle write strobe.
- `mbc_out_ifc_read` output 1: one-cycle read strobe.
- `mbc_out_ifc_read_data` input 32: read data from arm.
- `mbc_out_ifc_control` input 32: arm status; bit 0 = busy (no issue while set); bits 31:1 ignored.
- `busy` output 1: FIFO non-empty or FSM not IDLE.

## Operation
- FIFO push on `req_valid && req_ready`. Entry = {write, address, write_data}, 65 bits. Pointers are log2(FIFO_DEPTH)+1 bits wide. Full when the MSBs differ and the lower bits are equal. Empty when the pointers are equal.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
  - IDLE -> ISSUE when the FIFO is non-empty and `control[0]==0`. Pop the head into the output registers.
  - ISSUE (1 cycle): assert `write` or `read` with the registered address and data. On write, -> IDLE. On read, -> WAIT_RD and load the latency counter with READ_LATENCY-1.
  - WAIT_RD: decrement the counter each cycle. When the counter is 0, capture `read_data` into `rsp_data`, set `rsp_valid`, and -> RESP. With READ_LATENCY=1, the capture happens in the first WAIT_RD cycle.
  - RESP: hold `rsp_valid` and `rsp_data` stable until `rsp_ready`. On `rsp_valid && rsp_ready`, clear `rsp_valid` and -> IDLE.
- Only one transaction is outstanding at a time. Writes produce no response.
- Push and pop in the same cycle are allowed, including when full: pop frees a slot only in the next cycle. `req_ready` is computed from the current full flag only.
- The busy bit is sampled only in IDLE. Once ISSUE is entered, the transaction completes regardless of `control[0]`.
- Address and write_data outputs hold their last issued values between strobes. Strobes are 0 outside ISSUE.

## Timing
- Reset values:
  - `req_ready`=1.
  - `rsp_valid`=0 and `rsp_data`=0.
  - `mbc_out_ifc_address`=0, `write_data`=0, `write`=0, `read`=0.
  - `busy`=0.
  - FSM=IDLE, FIFO pointers=0.
- Reset mid-transaction discards the FIFO contents and any pending response. Strobes drop in the cycle after `reset` is sampled high.
- Write latency: a push in cycle N (FIFO empty, not busy) gives the strobe in cycle N+2. Cycle N+1 is IDLE seeing non-empty; cycle N+2 is ISSUE.
- Read latency: strobe at cycle S; `rsp_valid` rises at cycle S+READ_LATENCY+1.
- Best-case throughput: one write per 2 cycles. One read per READ_LATENCY+3 cycles when `rsp_ready` is held at 1.
- All outputs are registered except `req_ready` and `busy`, which are decoded from registered state.

## Test plan
- **Single write, idle bus.** Push write addr=0x1000, data=0xDEADBEEF at cycle 5. Required: `write`=1 for exactly cycle 7 with those values, and `rsp_valid` never asserts.
- **Read with READ_LATENCY=2.** Push read addr=0x20 while the arm model returns 0xCAFE0020. Required: `read` pulses at cycle S, then `rsp_valid`=1 with `rsp_data`=0xCAFE0020 at cycle S+3.
- **FIFO full.** Hold `control[0]`=1 and push 4 requests. Required: `req_ready`=0 after the 4th push, and a 5th `req_valid` is not accepted. Release busy. Required: the 4 strobes occur in push order, and `req_ready` returns to 1 the cycle after the first pop.
- **Response backpressure.** Read with `rsp_ready`=0 for 10 cycles. Required: `rsp_valid` and `rsp_data` are stable throughout, and no new strobe is issued even though the FIFO holds a queued write. After `rsp_ready`=1, the write strobe follows 2 cycles later.
- **Busy gating.** Raise `control[0]` in the same cycle the FSM enters ISSUE. Required: the current strobe completes. The next queued request is not issued until `control[0]` is 0 in IDLE.
- **Reset mid-read.** Assert `reset` during WAIT_RD with 2 entries queued. Required: after reset, `busy`=0, `rsp_valid`=0, `req_ready`=1, and no strobes fire for the discarded entries.

Source files
------------

// File: rtl/ssm_mbc.sv
// Memory bus controller: buffers host read/write requests in a FIFO and issues them one at a
// time as single-cycle strobes to the arm slave, returning read data on a valid/ready channel.
module ssm_mbc #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] mbc_out_ifc_address,
  output logic [31:0] mbc_out_ifc_write_data,
  output logic        mbc_out_ifc_write,
  output logic        mbc_out_ifc_read,
  input  logic [31:0] mbc_out_ifc_read_data,
  input  logic [31:0] mbc_out_ifc_control,
  output logic        busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] LatInit = 3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRd, StResp} state_e;

  state_e      state_q, state_d;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [64:0] fifo_mem [FIFO_DEPTH];
  logic [64:0] head;
  logic        full, empty, push, pop;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        write_q, write_d, read_q, read_d, rsp_valid_q, rsp_valid_d;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = req_valid && !full;
  assign head  = fifo_mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= {req_write, req_address, req_write_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = 1'b0;
    read_d      = 1'b0;
    lat_cnt_d   = lat_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      StIdle: begin
        // The arm busy bit only gates the start of a transaction.
        if (!empty && !mbc_out_ifc_control[0]) begin
          pop     = 1'b1;
          write_d = head[64];
          read_d  = !head[64];
          addr_d  = head[63:32];
          wdata_d = head[31:0];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (write_q) begin
          state_d = StIdle;
        end else begin
          lat_cnt_d = LatInit;
          state_d   = StWaitRd;
        end
      end
      StWaitRd: begin
        if (lat_cnt_q == 3'd0) begin
          rdata_d     = mbc_out_ifc_read_data;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      lat_cnt_q   <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      read_q      <= read_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign req_ready              = !full;
  assign busy                   = !empty || (state_q != StIdle);
  assign rsp_valid              = rsp_valid_q;
  assign rsp_data               = rdata_q;
  assign mbc_out_ifc_address    = addr_q;
  assign mbc_out_ifc_write_data = wdata_q;
  assign mbc_out_ifc_write      = write_q;
  assign mbc_out_ifc_read       = read_q;

endmodule

// File: tb/tb_ssm_mbc.sv
// Bench for ssm_mbc: directed scenarios plus randomized traffic, checked against a
// transaction-level model (ordered op queue, pending-response queue, FIFO occupancy count).
module tb_ssm_mbc;

  localparam int DEPTH = 4;
  localparam int RL    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_address, req_write_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, bus_ctrl;
  logic        bus_write, bus_read, busy;

  ssm_mbc #(.FIFO_DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_write             (req_write),
    .req_address           (req_address),
    .req_write_data        (req_write_data),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .rsp_data              (rsp_data),
    .mbc_out_ifc_address   (bus_addr),
    .mbc_out_ifc_write_data(bus_wdata),
    .mbc_out_ifc_write     (bus_write),
    .mbc_out_ifc_read      (bus_read),
    .mbc_out_ifc_read_data (bus_rdata),
    .mbc_out_ifc_control   (bus_ctrl),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  // Arm read model: data is a fixed function of the presented address.
  assign bus_rdata = 32'hCAFE0000 ^ bus_addr;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } op_t;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  op_t exp_q[$];
  logic [31:0] rsp_q[$];
  int occ = 0;
  int n_wr = 0, n_rd = 0, n_rise = 0;
  int last_wr_cyc = -1, last_rd_cyc = -1, last_rise_cyc = -1;
  logic [31:0] last_wr_addr = '0, last_wr_data = '0, last_rsp_data = '0;
  logic prev_ctrl = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0;
  logic [31:0] prev_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      rsp_q.delete();
      occ       = 0;
      prev_ctrl = 1'b0;
      prev_rv   = 1'b0;
      prev_rr   = 1'b0;
    end else begin
      if (bus_write || bus_read) begin
        op_t e;
        chk("single_strobe", {31'd0, bus_write && bus_read}, 32'd0);
        chk("issue_when_not_busy", {31'd0, prev_ctrl}, 32'd0);
        chk("one_outstanding", rsp_q.size(), 0);
        chk("strobe_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          occ--;
          chk("op_kind", {31'd0, bus_write}, {31'd0, e.w});
          chk("op_addr", bus_addr, e.a);
          if (e.w) begin
            chk("op_wdata", bus_wdata, e.d);
            n_wr++;
            last_wr_cyc  = cyc;
            last_wr_addr = bus_addr;
            last_wr_data = bus_wdata;
          end else begin
            rsp_q.push_back(32'hCAFE0000 ^ e.a);
            n_rd++;
            last_rd_cyc = cyc;
          end
        end
      end
      chk("req_ready", {31'd0, req_ready}, {31'd0, occ < DEPTH});
      if (req_valid && occ < DEPTH) begin
        exp_q.push_back('{w: req_write, a: req_address, d: req_write_data});
        occ++;
      end
      if (prev_rv && !prev_rr) begin
        chk("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_hold_data", rsp_data, prev_rdata);
      end
      if (rsp_valid) begin
        chk("rsp_pending", {31'd0, rsp_q.size() > 0}, 32'd1);
        if (!prev_rv) begin
          chk("rsp_latency", cyc, last_rd_cyc + RL + 1);
          n_rise++;
          last_rise_cyc = cyc;
        end
        if (rsp_ready && rsp_q.size() > 0) begin
          chk("rsp_data", rsp_data, rsp_q.pop_front());
          last_rsp_data = rsp_data;
        end
      end
      prev_ctrl  = bus_ctrl[0];
      prev_rv    = rsp_valid;
      prev_rr    = rsp_ready;
      prev_rdata = rsp_data;
    end
  end

  int acc_cyc;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit ok = 0;
    req_valid = 1'b1; req_write = w; req_address = a; req_write_data = d;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("push_accept", {31'd0, ok}, 32'd1);
    acc_cyc = cyc - 1;
  endtask

  initial begin
    int n0, r0, f0, c0, s0;
    bit got;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_write_data = '0;
    rsp_ready = 1'b1; bus_ctrl = '0;
    step(3);
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_strobes", {30'd0, bus_write, bus_read}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    step(1);

    // Single write, idle bus
    r0 = n_rise;
    push(1'b1, 32'h1000, 32'hDEADBEEF);
    step(6);
    chk("wr_latency", last_wr_cyc, acc_cyc + 2);
    chk("wr_addr", last_wr_addr, 32'h1000);
    chk("wr_data", last_wr_data, 32'hDEADBEEF);
    chk("wr_no_rsp", n_rise, r0);
    chk("addr_hold", bus_addr, 32'h1000);
    chk("wr_idle_busy", {31'd0, busy}, 32'd0);

    // Read, latency 2
    push(1'b0, 32'h20, 32'h0);
    step(8);
    chk("rd_strobe_cyc", last_rd_cyc, acc_cyc + 2);
    chk("rd_rsp_cyc", last_rise_cyc, last_rd_cyc + 3);
    chk("rd_rsp_data", last_rsp_data, 32'hCAFE0020);

    // FIFO full with arm busy
    n0 = n_wr + n_rd;
    bus_ctrl = 32'h1;
    push(1'b1, 32'h100, 32'hA0);
    push(1'b0, 32'h104, 32'h0);
    push(1'b1, 32'h108, 32'hA2);
    push(1'b1, 32'h10C, 32'hA3);
    @(negedge clk);
    chk("full_ready", {31'd0, req_ready}, 32'd0);
    chk("full_busy", {31'd0, busy}, 32'd1);
    step(1);
    req_valid = 1'b1; req_write = 1'b1; req_address = 32'h110; req_write_data = 32'hA4;
    step(3);
    req_valid = 1'b0;
    bus_ctrl  = 32'h0;
    @(negedge clk);
    chk("full_ready_pop_cycle", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("full_ready_after_pop", {31'd0, req_ready}, 32'd1);
    step(20);
    chk("full_drained", n_wr + n_rd, n0 + 4);
    chk("full_idle", {31'd0, busy}, 32'd0);

    // Response backpressure with a queued write behind the read
    rsp_ready = 1'b0;
    push(1'b0, 32'h3C, 32'h0);
    push(1'b1, 32'h40, 32'h55AA55AA);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    chk("bp_rsp_seen", {31'd0, got}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", rsp_data, 32'hCAFE003C);
      chk("bp_no_strobe", {30'd0, bus_write, bus_read}, 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    c0 = cyc;
    step(4);
    chk("bp_write_after", last_wr_cyc, c0 + 2);

    // Busy raised as the read enters issue
    push(1'b0, 32'h60, 32'h0);
    c0 = acc_cyc;
    push(1'b1, 32'h64, 32'h12345678);
    bus_ctrl = 32'h1;
    s0 = n_wr;
    step(10);
    chk("bg_rd_issued", last_rd_cyc, c0 + 2);
    chk("bg_rd_completed", last_rise_cyc, c0 + 2 + RL + 1);
    chk("bg_wr_held", n_wr, s0);
    chk("bg_busy", {31'd0, busy}, 32'd1);
    bus_ctrl = 32'h0;
    c0 = cyc;
    step(4);
    chk("bg_wr_released", last_wr_cyc, c0 + 1);

    // Reset during the read wait with two entries queued
    bus_ctrl = 32'h1;
    push(1'b0, 32'h80, 32'h0);
    push(1'b1, 32'h84, 32'h1);
    push(1'b1, 32'h88, 32'h2);
    bus_ctrl = 32'h0;
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    s0 = n_wr; r0 = n_rise; f0 = n_rd;
    @(negedge clk);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mr_req_ready", {31'd0, req_ready}, 32'd1);
    chk("mr_strobes", {30'd0, bus_write, bus_read}, 32'd0);
    step(10);
    chk("mr_no_wr", n_wr, s0);
    chk("mr_no_rd", n_rd, f0);
    chk("mr_no_rsp", n_rise, r0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      req_valid      = 1'($urandom_range(0, 1));
      req_write      = 1'($urandom_range(0, 1));
      req_address    = $urandom;
      req_write_data = $urandom;
      bus_ctrl       = $urandom;
      bus_ctrl[0]    = ($urandom_range(0, 9) < 3);
      rsp_ready      = ($urandom_range(0, 9) < 7);
      step(1);
    end
    req_valid = 1'b0; bus_ctrl = 32'h0; rsp_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) got = 1;
    end
    chk("rand_drained", {31'd0, got}, 32'd1);
    chk("rand_ops_left", exp_q.size(), 0);
    chk("rand_rsp_left", rsp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
